spi_target: RTL

- Memory-mapped SPI target (slave) peripheral; the far-end counterpart of the existing spi_master.
- Lets the SoC act as a mode-0, MSB-first, 8-bit SPI device for an external host.
- Sits on the core data bus beside the other peripherals. mem_ctl muxes its mem_rdata.
- Its pins share the uo_out/ui_in mux under control of ena.

---
 rtl/spi_target_pkg.sv | 33 +++
 rtl/spi_target_sync.sv | 26 ++
 rtl/spi_target.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_target_pkg.sv
// Shared constants and types for the SPI target peripheral.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_target_pkg;

    // Byte offsets inside the 16-byte register window
    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_TXDATA = 4'h8;
    localparam logic [3:0] REG_RXDATA = 4'hC;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IE_RX  = 1;
    localparam int CTRL_IE_TX  = 2;
    localparam int CTRL_IE_OVR = 3;

    // STATUS bit positions
    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_BUSY     = 3;

    // Shift engine states
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } eng_state_t;

    // Byte shifted out when the host clocks a frame with nothing queued
    localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_target_sync.sv
// N-stage synchronizer for one asynchronous pin; every stage resets to 1 (idle level of cs_n).
// Latency: N clk from pin to q.
// Backpressure: none.
// Ports: clk, rst_n (async active-low), d (async pin), q (synchronized level).
module spi_target_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/spi_target.sv
// Memory-mapped SPI target: mode 0, MSB first, 8-bit frames, with CTRL/STATUS/TXDATA/RXDATA registers.
// Latency: bus reads combinational; pin edges act SYNC_STAGES+1 clk after they occur.
// Backpressure: none; a byte completing while rx_valid is still set raises overrun and overwrites rx_hold.
// Ports: clk/rst_n; mem_addr/mem_wdata/mem_we/mem_re/mem_rdata core bus (rdata 0 when not addressed);
//        ena = CTRL.EN for the pin mux; spi_cs_n/spi_sclk/spi_mosi in; spi_miso/spi_miso_oe out; irq level.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [31:0] SPI_TARGET_BASE_ADDR = 32'h4000_6000,
    parameter int          SYNC_STAGES          = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        ena,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        irq
);

    // ---------------- pin synchronization and edge detection ----------------
    logic cs_s, sclk_s, mosi_s;
    logic cs_prev, sclk_prev;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    spi_target_sync #(.N(SYNC_STAGES)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_s));
    spi_target_sync #(.N(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s));
    spi_target_sync #(.N(SYNC_STAGES)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b1;
        end else begin
            cs_prev   <= cs_s;
            sclk_prev <= sclk_s;
        end
    end

    assign cs_fall   =  cs_prev   & ~cs_s;
    assign cs_rise   = ~cs_prev   &  cs_s;
    assign sclk_rise = ~sclk_prev &  sclk_s;
    assign sclk_fall =  sclk_prev & ~sclk_s;

    // ---------------- bus decode ----------------
    logic       hit;
    logic [3:0] offs;
    logic       re_q;
    logic       wr_ctrl, wr_status, wr_tx, rd_rx_clr;

    assign hit       = (mem_addr[31:4] == SPI_TARGET_BASE_ADDR[31:4]);
    assign offs      = mem_addr[3:0];
    assign wr_ctrl   = mem_we && hit && (offs == REG_CTRL);
    assign wr_status = mem_we && hit && (offs == REG_STATUS);
    assign wr_tx     = mem_we && hit && (offs == REG_TXDATA);
    // Only the first cycle of a read strobe consumes the received byte
    assign rd_rx_clr = mem_re && !re_q && hit && (offs == REG_RXDATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) re_q <= 1'b0;
        else        re_q <= mem_re;
    end

    // ---------------- engine FSM ----------------
    logic [3:0] ctrl;
    logic       en;
    eng_state_t state, state_nxt;
    logic       start, shift_rise, shift_fall, stop;

    assign en = ctrl[CTRL_EN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en && cs_fall)  state_nxt = ACTIVE;
            ACTIVE:  if (!en || cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Leaving ACTIVE masks any sclk edge seen in the same cycle
    always_comb begin
        start      = 1'b0;
        shift_rise = 1'b0;
        shift_fall = 1'b0;
        stop       = 1'b0;
        case (state)
            IDLE: start = en && cs_fall;
            ACTIVE: begin
                if (!en || cs_rise) begin
                    stop = 1'b1;
                end else begin
                    shift_rise = sclk_rise;
                    shift_fall = sclk_fall;
                end
            end
            default: ;
        endcase
    end

    // ---------------- shift datapath ----------------
    logic       rx_valid, tx_empty, overrun;
    logic [7:0] tx_hold, rx_hold, shreg, load_byte, rx_next;
    logic [2:0] bit_cnt;
    logic       miso_q;
    logic       byte_done, load;

    // One register serves both directions: MSB goes out, mosi enters at the LSB
    assign load_byte = tx_empty ? TX_IDLE_BYTE : tx_hold;
    assign rx_next   = {shreg[6:0], mosi_s};
    assign byte_done = shift_rise && (bit_cnt == 3'd7);
    assign load      = start || byte_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            miso_q  <= 1'b1;
        end else if (start) begin
            shreg   <= load_byte;
            bit_cnt <= '0;
            miso_q  <= load_byte[7];
        end else if (shift_rise) begin
            shreg   <= byte_done ? load_byte : rx_next;
            bit_cnt <= bit_cnt + 3'd1;
        end else if (shift_fall) begin
            miso_q  <= shreg[7];
        end else if (stop) begin
            miso_q  <= 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= '0;
            tx_hold  <= '0;
            tx_empty <= 1'b1;
            rx_hold  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= mem_wdata[3:0];

            // A write racing a load: the load takes the old tx_hold, the new byte stays queued
            if (wr_tx) begin
                tx_hold  <= mem_wdata[7:0];
                tx_empty <= 1'b0;
            end else if (load) begin
                tx_empty <= 1'b1;
            end

            // Capture beats a same-cycle read-clear, and that read does not count as an overrun
            if (byte_done) begin
                rx_hold  <= rx_next;
                rx_valid <= 1'b1;
            end else if (rd_rx_clr) begin
                rx_valid <= 1'b0;
            end

            if (byte_done && rx_valid && !rd_rx_clr) begin
                overrun <= 1'b1;
            end else if (wr_status && mem_wdata[STAT_OVERRUN]) begin
                overrun <= 1'b0;
            end
        end
    end

    // ---------------- read mux and outputs ----------------
    always_comb begin
        mem_rdata = '0;
        if (mem_re && hit) begin
            case (offs)
                REG_CTRL:   mem_rdata[3:0] = ctrl;
                REG_STATUS: begin
                    mem_rdata[STAT_RX_VALID] = rx_valid;
                    mem_rdata[STAT_TX_EMPTY] = tx_empty;
                    mem_rdata[STAT_OVERRUN]  = overrun;
                    mem_rdata[STAT_BUSY]     = ~cs_s;
                end
                REG_TXDATA: mem_rdata[7:0] = tx_hold;
                REG_RXDATA: mem_rdata[7:0] = rx_hold;
                default:    mem_rdata = '0;
            endcase
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^mem_wdata[31:8];

    assign ena         = en;
    assign spi_miso    = miso_q;
    assign spi_miso_oe = en & ~cs_s;
    assign irq         = (rx_valid & ctrl[CTRL_IE_RX])
                       | (tx_empty & ctrl[CTRL_IE_TX])
                       | (overrun  & ctrl[CTRL_IE_OVR]);

endmodule
